vm_rr_arbiter4: RTL and testbench

// - Round-robin arbiter sharing one 4-way resource among 4 requesters.
// - Drives the sel0/sel1 inputs of the 2-to-4 VM decoder; decoder output Sk enables requester k.
// - Holds a grant while the owner keeps requesting, then re-arbitrates fairly.
// - Sits between requester logic and the decoder, one instance per shared resource.

---
 rtl/vm_rr_arbiter4_if.sv | 28 ++
 rtl/vm_rr_arbiter4.sv | 101 ++++++++++
 tb/tb_vm_rr_arbiter4.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vm_rr_arbiter4_if.sv
// Request/grant bundle between requester logic and vm_rr_arbiter4.
// The master is the requester side; the slave is the arbiter driving the decoder selects.
interface vm_rr_arbiter4_if;
    logic [3:0] req;
    logic       sel0;
    logic       sel1;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        input  sel0,
        input  sel1,
        input  gnt,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output sel0,
        output sel1,
        output gnt,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/vm_rr_arbiter4.sv
// Four-way round-robin arbiter driving the sel1:sel0 inputs of a 2-to-4 VM decoder.
// Define TIMEOUT_EN to force release of an owner after MAX_HOLD grant cycles.
module vm_rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input logic             clk,
    input logic             rst_n,
    vm_rr_arbiter4_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    if (MAX_HOLD < 2 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cfg
        $error("vm_rr_arbiter4: MAX_HOLD must be in 2..2^CNT_W-1");
    end

    state_e     r_state;
    logic [1:0] r_owner;
    logic [1:0] r_last;
    logic [3:0] r_gnt;
    logic       r_valid;
    logic       r_timeout;

    logic [1:0] w_pick;
    logic       w_any;
    logic       w_hold;
    logic       w_expire;

    assign w_any  = |bus.req;
    assign w_hold = bus.req[r_owner];

    // Scan downward so the requester closest after r_last wins; r_last itself is last resort.
    always_comb begin
        w_pick = r_last;
        for (int i = 3; i >= 1; i--) begin
            if (bus.req[r_last + 2'(i)]) begin
                w_pick = r_last + 2'(i);
            end
        end
    end

`ifdef TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    // r_cnt is zero on the grant edge, so MAX_HOLD-1 marks the last allowed grant cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == StIdle) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_expire = (r_cnt == CNT_W'(MAX_HOLD - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_owner   <= 2'd0;
            r_last    <= 2'd3;
            r_gnt     <= 4'b0000;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_gnt   <= 4'b0001 << w_pick;
                        r_valid <= 1'b1;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (!w_hold || w_expire) begin
                        r_gnt     <= 4'b0000;
                        r_valid   <= 1'b0;
                        r_last    <= r_owner;
                        r_timeout <= w_hold;
                        r_state   <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.sel0      = r_owner[0];
    assign bus.sel1      = r_owner[1];
    assign bus.gnt       = r_gnt;
    assign bus.gnt_valid = r_valid;
    assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_vm_rr_arbiter4.sv
// Self-checking bench for vm_rr_arbiter4: vector table, corner-case sequences and a
// randomized run against a behavioural round-robin model (TIMEOUT_EN aware).
module tb_vm_rr_arbiter4;

    localparam int unsigned TbMaxHold = 4;
    localparam int unsigned TbCntW    = 5;

    logic clk;
    logic rst_n;

    vm_rr_arbiter4_if bus ();

    vm_rr_arbiter4 #(
        .MAX_HOLD (TbMaxHold),
        .CNT_W    (TbCntW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[22];

    // Behavioural model: owner/last as plain integers, hold as count of visible grant cycles.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_busy;
    bit m_to;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic v,
                             input logic [1:0] s, input logic t);
        check({tag, ".gnt"}, int'(bus.gnt), int'(g));
        check({tag, ".gnt_valid"}, int'(bus.gnt_valid), int'(v));
        check({tag, ".sel"}, int'({bus.sel1, bus.sel0}), int'(s));
        check({tag, ".timeout"}, int'(bus.timeout), int'(t));
    endtask

    task automatic step(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 3;
        m_hold  = 0;
        m_busy  = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (!m_busy) begin
            if (r != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    if (r[(m_last + k) % 4]) begin
                        m_owner = (m_last + k) % 4;
                        break;
                    end
                end
                m_busy = 1'b1;
                m_hold = 1;
            end
        end else if (!r[m_owner]) begin
            m_busy = 1'b0;
            m_last = m_owner;
`ifdef TIMEOUT_EN
        end else if (m_hold == int'(TbMaxHold)) begin
            m_busy = 1'b0;
            m_last = m_owner;
            m_to   = 1'b1;
`endif
        end else begin
            m_hold++;
        end
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] exp_g;

        // Fairness rotation 0,1,2,3,0 then the owner-1 -> owner-3 hand-over.
        tbl[0]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[3]  = '{4'b1110, 4'b0000, 1'b0, 2'd0};
        tbl[4]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
        tbl[5]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
        tbl[6]  = '{4'b1111, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{4'b1101, 4'b0000, 1'b0, 2'd1};
        tbl[8]  = '{4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[9]  = '{4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{4'b1111, 4'b0100, 1'b1, 2'd2};
        tbl[11] = '{4'b1011, 4'b0000, 1'b0, 2'd2};
        tbl[12] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
        tbl[13] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
        tbl[14] = '{4'b1111, 4'b1000, 1'b1, 2'd3};
        tbl[15] = '{4'b0111, 4'b0000, 1'b0, 2'd3};
        tbl[16] = '{4'b1111, 4'b0001, 1'b1, 2'd0};
        tbl[17] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[18] = '{4'b1011, 4'b0010, 1'b1, 2'd1};
        tbl[19] = '{4'b1001, 4'b0000, 1'b0, 2'd1};
        tbl[20] = '{4'b1001, 4'b1000, 1'b1, 2'd3};
        tbl[21] = '{4'b0000, 4'b0000, 1'b0, 2'd3};

        rst_n   = 1'b0;
        bus.req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].req);
            check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].valid, tbl[i].sel, 1'b0);
        end

`ifdef TIMEOUT_EN
        // req=0011 held: each owner is forced out after TbMaxHold cycles with a timeout pulse.
        for (int o = 0; o < 2; o++) begin
            exp_g = 4'b0001 << o;
            for (int c = 0; c < int'(TbMaxHold); c++) begin
                step(4'b0011);
                check_out($sformatf("to_own%0d_c%0d", o, c), exp_g, 1'b1, 2'(o), 1'b0);
            end
            step(4'b0011);
            check_out($sformatf("to_rel%0d", o), 4'b0000, 1'b0, 2'(o), 1'b1);
        end
        step(4'b0011);
        check_out("to_regrant0", 4'b0001, 1'b1, 2'd0, 1'b0);
        step(4'b0000);
        check_out("to_release", 4'b0000, 1'b0, 2'd0, 1'b0);
`else
        // Sole requester 2 held for 10 cycles, then released; selects keep index 2.
        for (int c = 0; c < 10; c++) begin
            step(4'b0100);
            check_out($sformatf("hold2_c%0d", c), 4'b0100, 1'b1, 2'd2, 1'b0);
        end
        step(4'b0000);
        check_out("hold2_rel", 4'b0000, 1'b0, 2'd2, 1'b0);
`endif

        // Asynchronous reset in the middle of owner 2's grant.
        step(4'b0100);
        check_out("pre_arst", 4'b0100, 1'b1, 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst", 4'b0000, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100);
        check_out("post_arst", 4'b0100, 1'b1, 2'd2, 1'b0);

        rst_n = 1'b0;
        step(4'b0000);
        rst_n = 1'b1;
        model_reset();
        rq = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            model_step(rq);
            step(rq);
            exp_g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            check_out($sformatf("rnd%0d", n), exp_g, m_busy, 2'(m_owner), m_to);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
